// File: rtl/pr5_pkg.sv
// Shared constants for the decode-to-execute stage: ALU operation codes,
// decoder ALU classes, funct3 values and the pipeline register state type.
package pr5_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_XOR = 4'b1010;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] CLASS_ADD  = 2'b00;
  localparam logic [1:0] CLASS_SUB  = 2'b01;
  localparam logic [1:0] CLASS_RTYP = 2'b10;
  localparam logic [1:0] CLASS_ITYP = 2'b11;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } stage_state_t;

endpackage

// File: rtl/id_ex_stage_alu_op_decode.sv
// Combinational translation of decoder ALU class plus funct3/funct7 bit 30
// into the 4-bit ALU operation code and an illegal-instruction flag.
module alu_op_decode
  import pr5_pkg::*;
(
  input  logic [1:0] alu_class,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_op,
  output logic       illegal
);

  always_comb begin
    alu_op  = ALU_ADD;
    illegal = 1'b0;
    case (alu_class)
      CLASS_ADD: alu_op = ALU_ADD;
      CLASS_SUB: alu_op = ALU_SUB;
      default: begin
        case (funct3)
          // bit 30 only selects SUB for register-register; for ADDI it is immediate data
          F3_ADD_SUB: alu_op = (alu_class == CLASS_RTYP && funct7_5) ? ALU_SUB : ALU_ADD;
          F3_SLL:     alu_op = ALU_SLL;
          F3_SLT:     alu_op = ALU_SLT;
          F3_SLTU:    alu_op = ALU_SLT;
          F3_XOR:     alu_op = ALU_XOR;
          F3_SR: begin
            if (funct7_5) begin
              alu_op  = ALU_ADD;
              illegal = 1'b1;
            end else begin
              alu_op = ALU_SRL;
            end
          end
          F3_OR:      alu_op = ALU_OR;
          F3_AND:     alu_op = ALU_AND;
          default:    alu_op = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline stage: operand selection with writeback
// forwarding, ALU op decode, and a one-entry valid/ready pipeline register.
module id_ex_stage
  import pr5_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [1:0]      alu_class,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic            src_a_pc,
  input  logic            src_b_imm,
  input  logic [4:0]      rd,
  input  logic            reg_write,
  input  logic            fwd_valid,
  input  logic [4:0]      fwd_rd,
  input  logic [XLEN-1:0] fwd_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_operation,
  output logic [XLEN-1:0] alu_x,
  output logic [XLEN-1:0] alu_y,
  output logic [4:0]      out_rd,
  output logic            out_reg_write,
  output logic            out_illegal
);

  stage_state_t state, state_next;

  logic [3:0]      dec_op;
  logic            dec_illegal;
  logic [XLEN-1:0] rs1_val, rs2_val, x_sel, y_sel, y_final;
  logic            accept;

  alu_op_decode u_decode (
    .alu_class (alu_class),
    .funct3    (funct3),
    .funct7_5  (funct7_5),
    .alu_op    (dec_op),
    .illegal   (dec_illegal)
  );

  // x0 reads as zero and is never a forwarding target
  always_comb begin
    rs1_val = rs1_data;
    rs2_val = rs2_data;
    if (rs1_addr == 5'd0)
      rs1_val = '0;
    else if (fwd_valid && fwd_rd == rs1_addr)
      rs1_val = fwd_data;
    if (rs2_addr == 5'd0)
      rs2_val = '0;
    else if (fwd_valid && fwd_rd == rs2_addr)
      rs2_val = fwd_data;
  end

  always_comb begin
    x_sel   = src_a_pc ? pc : rs1_val;
    y_sel   = src_b_imm ? imm : rs2_val;
    y_final = y_sel;
    if (dec_op == ALU_SLL || dec_op == ALU_SRL)
      y_final = {{(XLEN-5){1'b0}}, y_sel[4:0]};
  end

  assign out_valid = (state == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (reset)
      state <= EMPTY;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (flush)
      state_next = EMPTY;
    else if (accept)
      state_next = FULL;
    else if (out_ready)
      state_next = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_operation <= ALU_AND;
      alu_x         <= '0;
      alu_y         <= '0;
      out_rd        <= '0;
      out_reg_write <= 1'b0;
      out_illegal   <= 1'b0;
    end else if (accept) begin
      alu_operation <= dec_op;
      alu_x         <= x_sel;
      alu_y         <= y_final;
      out_rd        <= rd;
      out_reg_write <= reg_write && !dec_illegal;
      out_illegal   <= dec_illegal;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: table-driven vectors streamed through
// a scoreboard queue, plus hand-written hold, flush and reset sequences.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready;
  logic [4:0]  rs1_addr, rs2_addr, rd, fwd_rd, out_rd;
  logic [31:0] rs1_data, rs2_data, pc, imm, fwd_data, alu_x, alu_y;
  logic [1:0]  alu_class;
  logic [2:0]  funct3;
  logic        funct7_5, src_a_pc, src_b_imm, reg_write, fwd_valid;
  logic        out_valid, out_ready, out_reg_write, out_illegal;
  logic [3:0]  alu_operation;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [4:0]  rd;
    logic        rw;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [1:0]  cls;
    logic [2:0]  f3;
    logic        f7;
    logic        a_pc;
    logic        b_imm;
    logic [4:0]  rs1a;
    logic [31:0] rs1d;
    logic [4:0]  rs2a;
    logic [31:0] rs2d;
    logic [31:0] pcv;
    logic [31:0] immv;
    logic        fv;
    logic [4:0]  frd;
    logic [31:0] fdata;
    logic [4:0]  rdv;
    logic        rw;
    exp_t        e;
  } vec_t;

  vec_t  tbl[18];
  exp_t  sb[$];
  exp_t  cur_exp;
  logic  model_full;
  int    tests_run = 0;
  int    tests_failed = 0;

  id_ex_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .pc(pc), .imm(imm), .alu_class(alu_class), .funct3(funct3), .funct7_5(funct7_5),
    .src_a_pc(src_a_pc), .src_b_imm(src_b_imm), .rd(rd), .reg_write(reg_write),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready), .alu_operation(alu_operation),
    .alu_x(alu_x), .alu_y(alu_y), .out_rd(out_rd), .out_reg_write(out_reg_write),
    .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  function automatic vec_t mkv(logic [1:0] cls, logic [2:0] f3, logic f7, logic a_pc, logic b_imm,
                               logic [4:0] rs1a, logic [31:0] rs1d, logic [4:0] rs2a, logic [31:0] rs2d,
                               logic [31:0] pcv, logic [31:0] immv, logic fv, logic [4:0] frd,
                               logic [31:0] fdata, logic [4:0] rdv, logic rw, logic [3:0] e_op,
                               logic [31:0] e_x, logic [31:0] e_y, logic e_rw, logic e_ill);
    vec_t v;
    v.cls = cls; v.f3 = f3; v.f7 = f7; v.a_pc = a_pc; v.b_imm = b_imm;
    v.rs1a = rs1a; v.rs1d = rs1d; v.rs2a = rs2a; v.rs2d = rs2d;
    v.pcv = pcv; v.immv = immv; v.fv = fv; v.frd = frd; v.fdata = fdata;
    v.rdv = rdv; v.rw = rw;
    v.e.op = e_op; v.e.x = e_x; v.e.y = e_y; v.e.rd = rdv; v.e.rw = e_rw; v.e.ill = e_ill;
    return v;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkVal("alu_operation", {28'd0, alu_operation}, {28'd0, e.op});
    checkVal("alu_x", alu_x, e.x);
    checkVal("alu_y", alu_y, e.y);
    checkVal("out_rd", {27'd0, out_rd}, {27'd0, e.rd});
    checkVal("out_reg_write", {31'd0, out_reg_write}, {31'd0, e.rw});
    checkVal("out_illegal", {31'd0, out_illegal}, {31'd0, e.ill});
  endtask

  task automatic applyStimulus(input vec_t v);
    alu_class = v.cls; funct3 = v.f3; funct7_5 = v.f7;
    src_a_pc = v.a_pc; src_b_imm = v.b_imm;
    rs1_addr = v.rs1a; rs1_data = v.rs1d; rs2_addr = v.rs2a; rs2_data = v.rs2d;
    pc = v.pcv; imm = v.immv;
    fwd_valid = v.fv; fwd_rd = v.frd; fwd_data = v.fdata;
    rd = v.rdv; reg_write = v.rw;
    cur_exp = v.e;
  endtask

  // One cycle: check against the scoreboard before the edge, then advance the model.
  task automatic tick();
    logic acc;
    #1;
    checkVal("out_valid", {31'd0, out_valid}, {31'd0, model_full});
    checkVal("in_ready", {31'd0, in_ready}, {31'd0, (!model_full || out_ready)});
    if (model_full) begin
      if (sb.size() == 0) begin
        checkVal("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        checkOutput(sb[0]);
        if (out_ready || flush) void'(sb.pop_front());
      end
    end
    acc = in_valid && (!model_full || out_ready) && !flush;
    if (acc) sb.push_back(cur_exp);
    if (flush)          model_full = 1'b0;
    else if (acc)       model_full = 1'b1;
    else if (out_ready) model_full = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_full = 1'b0;
    sb.delete();
    #1;
    checkVal("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkVal("reset_in_ready", {31'd0, in_ready}, 32'd1);
    checkVal("reset_alu_operation", {28'd0, alu_operation}, 32'd0);
    checkVal("reset_alu_x", alu_x, 32'd0);
    checkVal("reset_alu_y", alu_y, 32'd0);
    checkVal("reset_out_rd", {27'd0, out_rd}, 32'd0);
    checkVal("reset_out_reg_write", {31'd0, out_reg_write}, 32'd0);
    checkVal("reset_out_illegal", {31'd0, out_illegal}, 32'd0);
  endtask

  initial begin
    tbl[0]  = mkv(2'b10, 3'b000, 1, 0, 0, 5'd1, 32'd10,   5'd2, 32'd3,   0, 0, 0, 0, 0, 5'd3, 1, 4'b0110, 32'd10, 32'd3, 1, 0);
    tbl[1]  = mkv(2'b10, 3'b000, 0, 0, 0, 5'd1, 32'd7,    5'd2, 32'd9,   0, 0, 0, 0, 0, 5'd4, 1, 4'b0010, 32'd7, 32'd9, 1, 0);
    tbl[2]  = mkv(2'b11, 3'b001, 0, 0, 1, 5'd1, 32'h1234, 5'd2, 32'h99,  0, 32'h0000_0FE5, 0, 0, 0, 5'd5, 1, 4'b1000, 32'h1234, 32'd5, 1, 0);
    tbl[3]  = mkv(2'b11, 3'b101, 1, 0, 1, 5'd1, 32'h8000_0000, 5'd2, 0, 0, 32'h403, 0, 0, 0, 5'd6, 1, 4'b0010, 32'h8000_0000, 32'h403, 0, 1);
    tbl[4]  = mkv(2'b00, 3'b010, 0, 0, 1, 5'd5, 32'd0,    5'd2, 32'd0,   0, 32'd4, 1, 5'd5, 32'hDEAD_BEEF, 5'd7, 1, 4'b0010, 32'hDEAD_BEEF, 32'd4, 1, 0);
    tbl[5]  = mkv(2'b00, 3'b010, 0, 0, 1, 5'd0, 32'h55,   5'd2, 32'd0,   0, 32'd4, 1, 5'd0, 32'hDEAD_BEEF, 5'd7, 1, 4'b0010, 32'd0, 32'd4, 1, 0);
    tbl[6]  = mkv(2'b10, 3'b101, 0, 0, 0, 5'd3, 32'hF0,   5'd4, 32'hFFFF_FF23, 0, 0, 0, 0, 0, 5'd8, 1, 4'b1001, 32'hF0, 32'h3, 1, 0);
    tbl[7]  = mkv(2'b11, 3'b011, 0, 0, 1, 5'd3, 32'h11,   5'd0, 32'd0,   0, 32'h20, 0, 0, 0, 5'd9, 1, 4'b0111, 32'h11, 32'h20, 1, 0);
    tbl[8]  = mkv(2'b10, 3'b100, 0, 0, 0, 5'd3, 32'hA5,   5'd4, 32'h0F,  0, 0, 0, 0, 0, 5'd10, 1, 4'b1010, 32'hA5, 32'h0F, 1, 0);
    tbl[9]  = mkv(2'b10, 3'b110, 0, 0, 0, 5'd3, 32'hA5,   5'd4, 32'h0F,  0, 0, 0, 0, 0, 5'd11, 1, 4'b0001, 32'hA5, 32'h0F, 1, 0);
    tbl[10] = mkv(2'b10, 3'b111, 0, 0, 0, 5'd3, 32'hA5,   5'd4, 32'h0F,  0, 0, 0, 0, 0, 5'd12, 1, 4'b0000, 32'hA5, 32'h0F, 1, 0);
    tbl[11] = mkv(2'b01, 3'b001, 0, 0, 0, 5'd3, 32'd20,   5'd4, 32'h40,  0, 0, 0, 0, 0, 5'd0, 0, 4'b0110, 32'd20, 32'h40, 0, 0);
    tbl[12] = mkv(2'b00, 3'b000, 0, 1, 1, 5'd3, 32'h77,   5'd0, 32'd0,   32'h1000, 32'h2000, 0, 0, 0, 5'd13, 1, 4'b0010, 32'h1000, 32'h2000, 1, 0);
    tbl[13] = mkv(2'b11, 3'b000, 1, 0, 1, 5'd3, 32'd100,  5'd0, 32'd0,   0, 32'hFFFF_FC00, 0, 0, 0, 5'd14, 1, 4'b0010, 32'd100, 32'hFFFF_FC00, 1, 0);
    tbl[14] = mkv(2'b10, 3'b000, 0, 0, 0, 5'd7, 32'd1,    5'd8, 32'd2,   0, 0, 1, 5'd8, 32'h500, 5'd15, 1, 4'b0010, 32'd1, 32'h500, 1, 0);
    tbl[15] = mkv(2'b10, 3'b000, 0, 0, 0, 5'd7, 32'd1,    5'd8, 32'd2,   0, 0, 0, 5'd8, 32'h500, 5'd16, 1, 4'b0010, 32'd1, 32'd2, 1, 0);
    tbl[16] = mkv(2'b10, 3'b000, 0, 0, 0, 5'd7, 32'd1,    5'd0, 32'h33,  0, 0, 1, 5'd0, 32'h500, 5'd17, 1, 4'b0010, 32'd1, 32'd0, 1, 0);
    tbl[17] = mkv(2'b10, 3'b001, 0, 0, 0, 5'd3, 32'd1,    5'd9, 32'h44,  0, 0, 1, 5'd9, 32'hFFFF_FFE7, 5'd18, 1, 4'b1000, 32'd1, 32'h7, 1, 0);

    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    model_full = 1'b0;
    applyStimulus(tbl[0]);
    @(negedge clk);
    doReset();
    tick();

    // Back-to-back streaming of the whole table with the consumer always ready.
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      applyStimulus(tbl[i]);
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();

    // Hold for three cycles while the next instruction waits and forwarding changes.
    in_valid = 1'b1;
    applyStimulus(tbl[4]);
    tick();
    applyStimulus(tbl[1]);
    out_ready = 1'b0;
    fwd_valid = 1'b1; fwd_rd = 5'd1; fwd_data = 32'h1111_2222;
    cur_exp.x = 32'h1111_2222;
    repeat (3) tick();
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();

    // Flush a held instruction while a new one is offered.
    in_valid = 1'b1;
    flush = 1'b1;
    applyStimulus(tbl[2]);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    tick();

    // Flush from empty while an instruction is offered.
    in_valid = 1'b1;
    flush = 1'b1;
    applyStimulus(tbl[6]);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    tick();

    // Reset while holding an instruction drops it.
    in_valid = 1'b1;
    out_ready = 1'b0;
    applyStimulus(tbl[3]);
    tick();
    in_valid = 1'b0;
    tick();
    doReset();
    out_ready = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
